// File: rtl/mlp_2layer_seq.sv
// Purpose : sequential 2-layer MLP (dense+bias -> ReLU -> dense+bias -> logits + argmax) on one shared MAC.
// Latency : HIDDEN*(IN_SIZE+1) + OUT_SIZE*(HIDDEN+1) + 1 cycles from accept edge to out_valid.
// Backpr. : in_ready low while an inference is in flight; result held in OUT until out_ready.
// Ports   : clk/rst_n; wr_en/wr_sel/wr_addr/wr_data load W1,B1,W2,B2 (honoured only while idle);
//           in_valid/in_ready/in_data input vector; out_valid/out_ready/out_logits/out_class result;
//           busy is high whenever the engine is not idle.
// Config  : define NN_SAT_EN for a saturating fixed-point format; otherwise results wrap to WIDTH bits.
module mlp_2layer_seq #(
    parameter int IN_SIZE  = 2,
    parameter int HIDDEN   = 64,
    parameter int OUT_SIZE = 3,
    parameter int WIDTH    = 16,
    parameter int FRAC     = 8,
    parameter int ACC_W    = 40,
    localparam int MAX_IO  = (IN_SIZE > OUT_SIZE) ? IN_SIZE : OUT_SIZE,
    localparam int WA_W    = (HIDDEN * MAX_IO > 1) ? $clog2(HIDDEN * MAX_IO) : 1,
    localparam int CLS_W   = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [1:0]                  wr_sel,
    input  logic [WA_W-1:0]             wr_addr,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [IN_SIZE*WIDTH-1:0]    in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_SIZE*WIDTH-1:0]   out_logits,
    output logic [CLS_W-1:0]            out_class,
    output logic                        busy
);

    localparam int MAX_K  = (IN_SIZE > HIDDEN) ? IN_SIZE : HIDDEN;
    localparam int MAX_N  = (HIDDEN > OUT_SIZE) ? HIDDEN : OUT_SIZE;
    localparam int K_W    = (MAX_K > 1) ? $clog2(MAX_K) : 1;
    localparam int N_W    = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam int IN_W   = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam int H_W    = (HIDDEN > 1) ? $clog2(HIDDEN) : 1;
    localparam int O_W    = CLS_W;
    localparam int D1     = HIDDEN * IN_SIZE;
    localparam int D2     = OUT_SIZE * HIDDEN;
    localparam int A1_W   = (D1 > 1) ? $clog2(D1) : 1;
    localparam int A2_W   = (D2 > 1) ? $clog2(D2) : 1;
    localparam int PROD_W = 2 * WIDTH;

    typedef logic signed [WIDTH-1:0] data_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_L1_MAC,
        S_L1_ACT,
        S_L2_MAC,
        S_L2_FIN,
        S_ARG,
        S_OUT
    } state_t;

    // Parameter register files: written only through the write port, never reset.
    data_t w1_q [D1];
    data_t b1_q [HIDDEN];
    data_t w2_q [D2];
    data_t b2_q [OUT_SIZE];

    state_t                    state_q;
    logic [N_W-1:0]            n_q;
    logic [K_W-1:0]            k_q;
    acc_t                      acc_q;
    data_t                     x_q [IN_SIZE];
    data_t                     h_q [HIDDEN];
    data_t                     logit_q [OUT_SIZE];
    logic                      in_ready_q;
    logic                      out_valid_q;
    logic                      busy_q;
    logic [OUT_SIZE*WIDTH-1:0] out_logits_q;
    logic [CLS_W-1:0]          out_class_q;

    logic                      wr_ok;
    logic [A1_W-1:0]           w1_idx;
    logic [A2_W-1:0]           w2_idx;
    data_t                     mul_a;
    data_t                     mul_b;
    data_t                     bias_v;
    logic signed [PROD_W-1:0]  prod;
    acc_t                      acc_d;
    data_t                     fmt_v;
    data_t                     relu_v;
    data_t                     best_v;
    logic [O_W-1:0]            cls_d;

    assign wr_ok = wr_en && (state_q == S_IDLE);

    // The write range check matters: the narrower per-array index would otherwise alias.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            case (wr_sel)
                2'd0: if (int'(wr_addr) < D1)       w1_q[wr_addr[A1_W-1:0]] <= wr_data;
                2'd1: if (int'(wr_addr) < HIDDEN)   b1_q[wr_addr[H_W-1:0]]  <= wr_data;
                2'd2: if (int'(wr_addr) < D2)       w2_q[wr_addr[A2_W-1:0]] <= wr_data;
                2'd3: if (int'(wr_addr) < OUT_SIZE) b2_q[wr_addr[O_W-1:0]]  <= wr_data;
                default: ;
            endcase
        end
    end

    // Operand selection for the shared MAC: layer 1 uses W1/x/B1, layer 2 uses W2/h/B2.
    always_comb begin
        w1_idx = A1_W'(int'(n_q) * IN_SIZE + int'(k_q));
        w2_idx = A2_W'(int'(n_q) * HIDDEN + int'(k_q));
        if (state_q == S_L2_MAC) begin
            mul_a  = w2_q[w2_idx];
            mul_b  = h_q[k_q[H_W-1:0]];
            bias_v = b2_q[n_q[O_W-1:0]];
        end else begin
            mul_a  = w1_q[w1_idx];
            mul_b  = x_q[k_q[IN_W-1:0]];
            bias_v = b1_q[n_q[H_W-1:0]];
        end
    end

    // The bias is folded in with the first product, so the RAM read happens after any
    // write that landed on the accept edge.
    always_comb begin
        prod  = PROD_W'(mul_a) * PROD_W'(mul_b);
        acc_d = ((k_q == '0) ? (ACC_W'(bias_v) <<< FRAC) : acc_q) + ACC_W'(prod);
    end

`ifdef NN_SAT_EN
    localparam acc_t SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam acc_t SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    acc_t acc_sh;

    always_comb begin
        acc_sh = acc_q >>> FRAC;
        if (acc_sh > SAT_MAX) begin
            fmt_v = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (acc_sh < SAT_MIN) begin
            fmt_v = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            fmt_v = acc_sh[WIDTH-1:0];
        end
    end
`else
    // Floor shift then keep the low WIDTH bits: a plain slice of the accumulator.
    always_comb begin
        fmt_v = acc_q[FRAC +: WIDTH];
    end
`endif

    assign relu_v = fmt_v[WIDTH-1] ? '0 : fmt_v;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        best_v = logit_q[0];
        cls_d  = '0;
        for (int o = 1; o < OUT_SIZE; o++) begin
            if (logit_q[o] > best_v) begin
                best_v = logit_q[o];
                cls_d  = O_W'(o);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            k_q          <= '0;
            acc_q        <= '0;
            for (int i = 0; i < IN_SIZE; i++)  x_q[i]     <= '0;
            for (int i = 0; i < HIDDEN; i++)   h_q[i]     <= '0;
            for (int i = 0; i < OUT_SIZE; i++) logit_q[i] <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            out_logits_q <= '0;
            out_class_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < IN_SIZE; i++) x_q[i] <= in_data[i*WIDTH +: WIDTH];
                        n_q        <= '0;
                        k_q        <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_L1_MAC;
                    end
                end
                S_L1_MAC: begin
                    acc_q <= acc_d;
                    if (k_q == K_W'(IN_SIZE - 1)) begin
                        k_q     <= '0;
                        state_q <= S_L1_ACT;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                S_L1_ACT: begin
                    h_q[n_q[H_W-1:0]] <= relu_v;
                    if (n_q == N_W'(HIDDEN - 1)) begin
                        n_q     <= '0;
                        state_q <= S_L2_MAC;
                    end else begin
                        n_q     <= n_q + 1'b1;
                        state_q <= S_L1_MAC;
                    end
                end
                S_L2_MAC: begin
                    acc_q <= acc_d;
                    if (k_q == K_W'(HIDDEN - 1)) begin
                        k_q     <= '0;
                        state_q <= S_L2_FIN;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                S_L2_FIN: begin
                    logit_q[n_q[O_W-1:0]] <= fmt_v;
                    if (n_q == N_W'(OUT_SIZE - 1)) begin
                        n_q     <= '0;
                        state_q <= S_ARG;
                    end else begin
                        n_q     <= n_q + 1'b1;
                        state_q <= S_L2_MAC;
                    end
                end
                // Dedicated cycle for the argmax compare chain before publishing the result.
                S_ARG: begin
                    for (int o = 0; o < OUT_SIZE; o++) out_logits_q[o*WIDTH +: WIDTH] <= logit_q[o];
                    out_class_q <= cls_d;
                    out_valid_q <= 1'b1;
                    state_q     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_logits = out_logits_q;
    assign out_class  = out_class_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mlp_2layer_seq.sv
// Bench for mlp_2layer_seq with HIDDEN=2: directed scenarios plus randomized vectors
// compared against an arithmetic reference model of the network.
module tb_mlp_2layer_seq;

    localparam int IN_SIZE  = 2;
    localparam int HIDDEN   = 2;
    localparam int OUT_SIZE = 3;
    localparam int WIDTH    = 16;
    localparam int FRAC     = 8;
    localparam int ACC_W    = 40;
    localparam int WA_W     = 3;
    localparam int CLS_W    = 2;
    localparam int LAT      = HIDDEN*(IN_SIZE+1) + OUT_SIZE*(HIDDEN+1) + 1;
    localparam int BOUND    = 400;

    logic                      clk;
    logic                      rst_n;
    logic                      wr_en;
    logic [1:0]                wr_sel;
    logic [WA_W-1:0]           wr_addr;
    logic [WIDTH-1:0]          wr_data;
    logic                      in_valid;
    logic                      in_ready;
    logic [IN_SIZE*WIDTH-1:0]  in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [OUT_SIZE*WIDTH-1:0] out_logits;
    logic [CLS_W-1:0]          out_class;
    logic                      busy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference copies of the parameter arrays.
    logic signed [15:0] w1_m [4];
    logic signed [15:0] b1_m [2];
    logic signed [15:0] w2_m [6];
    logic signed [15:0] b2_m [3];

    mlp_2layer_seq #(
        .IN_SIZE (IN_SIZE),
        .HIDDEN  (HIDDEN),
        .OUT_SIZE(OUT_SIZE),
        .WIDTH   (WIDTH),
        .FRAC    (FRAC),
        .ACC_W   (ACC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_logits(out_logits),
        .out_class (out_class),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // value/2^FRAC rounded toward minus infinity, then reduced to 16 bits.
    function automatic logic signed [15:0] fmt_m(input longint v);
        longint s;
        s = v >>> FRAC;
`ifdef NN_SAT_EN
        if (s > 32767)  return 16'sh7FFF;
        if (s < -32768) return 16'sh8000;
`endif
        return s[15:0];
    endfunction

    task automatic model_run(input logic signed [15:0] x0, input logic signed [15:0] x1,
                             output logic [47:0] lg, output logic [1:0] cls);
        logic signed [15:0] x [2];
        logic signed [15:0] h [2];
        logic signed [15:0] l [3];
        longint acc;
        x[0] = x0;
        x[1] = x1;
        for (int n = 0; n < 2; n++) begin
            acc = longint'(b1_m[n]) <<< FRAC;
            for (int k = 0; k < 2; k++) acc += longint'(w1_m[n*2+k]) * longint'(x[k]);
            h[n] = fmt_m(acc);
            if (h[n] < 0) h[n] = 16'sh0000;
        end
        for (int o = 0; o < 3; o++) begin
            acc = longint'(b2_m[o]) <<< FRAC;
            for (int n = 0; n < 2; n++) acc += longint'(w2_m[o*2+n]) * longint'(h[n]);
            l[o] = fmt_m(acc);
        end
        cls = 2'd0;
        for (int o = 1; o < 3; o++) if (l[o] > l[cls]) cls = 2'(o);
        lg = {l[2], l[1], l[0]};
    endtask

    // Stimulus helpers (inputs change 1 time unit after the rising edge).
    task automatic wr(input logic [1:0] sel, input int addr, input logic signed [15:0] d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 3'(addr);
        wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        case (sel)
            2'd0: if (addr < 4) w1_m[addr] = d;
            2'd1: if (addr < 2) b1_m[addr] = d;
            2'd2: if (addr < 6) w2_m[addr] = d;
            default: if (addr < 3) b2_m[addr] = d;
        endcase
    endtask

    task automatic load_default;
        wr(0, 0, 16'sh0100); wr(0, 1, 16'sh0000); wr(0, 2, 16'sh0000); wr(0, 3, 16'sh0100);
        wr(1, 0, 16'sh0000); wr(1, 1, 16'sh0000);
        wr(2, 0, 16'sh0100); wr(2, 1, 16'sh0000); wr(2, 2, 16'sh0000); wr(2, 3, 16'sh0100);
        wr(2, 4, 16'sh0100); wr(2, 5, 16'sh0100);
        wr(3, 0, 16'sh0000); wr(3, 1, 16'sh0000); wr(3, 2, 16'sh0000);
    endtask

    task automatic send(input logic [15:0] x0, input logic [15:0] x1);
        in_valid = 1'b1;
        in_data  = {x1, x0};
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < BOUND) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic release_out;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        n_cmp++; if (in_ready !== 1'b1)    begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0)   begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_logits !== 48'h0) begin n_err++; $display("FAIL rst_logits: got %h want 0", out_logits); end
        n_cmp++; if (out_class !== 2'd0)   begin n_err++; $display("FAIL rst_class: got %0d want 0", out_class); end
        n_cmp++; if (busy !== 1'b0)        begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic(input string tag);
        int cyc;
        send(16'h0200, 16'h0300);
        n_cmp++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL %s_busy: got busy=%b in_ready=%b want 1/0", tag, busy, in_ready); end
        wait_out(cyc);
        n_cmp++; if (cyc !== LAT) begin n_err++; $display("FAIL %s_latency: got %0d want %0d", tag, cyc, LAT); end
        n_cmp++; if (out_logits !== 48'h0500_0300_0200) begin n_err++; $display("FAIL %s_logits: got %h want 050003000200", tag, out_logits); end
        n_cmp++; if (out_class !== 2'd2) begin n_err++; $display("FAIL %s_class: got %0d want 2", tag, out_class); end
        release_out;
        n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL %s_idle: got busy=%b in_ready=%b out_valid=%b want 0/1/0", tag, busy, in_ready, out_valid);
        end
    endtask

    task automatic test_relu_tie;
        int cyc;
        send(16'hFF00, 16'h0080);
        wait_out(cyc);
        n_cmp++; if (out_logits !== 48'h0080_0080_0000) begin n_err++; $display("FAIL relu_logits: got %h want 008000800000", out_logits); end
        n_cmp++; if (out_class !== 2'd1) begin n_err++; $display("FAIL tie_class: got %0d want 1", out_class); end
        release_out;
    endtask

    task automatic test_bias;
        int cyc;
        wr(3, 0, 16'sh0100);
        send(16'h0000, 16'h0000);
        wait_out(cyc);
        n_cmp++; if (out_logits !== 48'h0000_0000_0100) begin n_err++; $display("FAIL bias_logits: got %h want 000000000100", out_logits); end
        n_cmp++; if (out_class !== 2'd0) begin n_err++; $display("FAIL bias_class: got %0d want 0", out_class); end
        release_out;
        wr(3, 0, 16'sh0000);
    endtask

    task automatic test_sat;
        int cyc;
        logic [15:0] exp_l2;
        logic [1:0]  exp_c;
`ifdef NN_SAT_EN
        exp_l2 = 16'h7FFF;
        exp_c  = 2'd2;
`else
        exp_l2 = 16'hFF02;
        exp_c  = 2'd0;
`endif
        wr(2, 4, 16'sh7FFF);
        wr(2, 5, 16'sh7FFF);
        send(16'h7F00, 16'h7F00);
        wait_out(cyc);
        n_cmp++; if (out_logits[47:32] !== exp_l2) begin n_err++; $display("FAIL fmt_logit2: got %h want %h", out_logits[47:32], exp_l2); end
        n_cmp++; if (out_logits[31:0] !== 32'h7F00_7F00) begin n_err++; $display("FAIL fmt_logit01: got %h want 7f007f00", out_logits[31:0]); end
        n_cmp++; if (out_class !== exp_c) begin n_err++; $display("FAIL fmt_class: got %0d want %0d", out_class, exp_c); end
        release_out;
        wr(2, 4, 16'sh0100);
        wr(2, 5, 16'sh0100);
    endtask

    task automatic test_stall;
        int cyc;
        send(16'h0200, 16'h0300);
        wait_out(cyc);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 32'($urandom);
            wr_en    = 1'b1;
            wr_sel   = 2'd0;
            wr_addr  = 3'd0;
            wr_data  = 16'h1234;
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b want 1", i, out_valid); end
            n_cmp++; if (out_logits !== 48'h0500_0300_0200) begin n_err++; $display("FAIL stall_logits[%0d]: got %h want 050003000200", i, out_logits); end
            n_cmp++; if (out_class !== 2'd2) begin n_err++; $display("FAIL stall_class[%0d]: got %0d want 2", i, out_class); end
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready); end
        end
        in_valid = 1'b0;
        wr_en    = 1'b0;
        release_out;
        n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release: got busy=%b in_ready=%b want 0/1", busy, in_ready); end
        test_basic("stall_after");
    endtask

    task automatic test_write_handshake;
        int cyc;
        logic [47:0] exp_l;
        logic [1:0]  exp_c;
        wr_en    = 1'b1;
        wr_sel   = 2'd0;
        wr_addr  = 3'd0;
        wr_data  = 16'h0200;
        in_valid = 1'b1;
        in_data  = {16'h0300, 16'h0200};
        @(posedge clk); #1;
        wr_en    = 1'b0;
        in_valid = 1'b0;
        w1_m[0]  = 16'sh0200;
        model_run(16'sh0200, 16'sh0300, exp_l, exp_c);
        wait_out(cyc);
        n_cmp++; if (out_logits !== 48'h0700_0300_0400) begin n_err++; $display("FAIL wrhs_logits: got %h want 070003000400", out_logits); end
        n_cmp++; if (out_logits !== exp_l) begin n_err++; $display("FAIL wrhs_model: got %h want %h", out_logits, exp_l); end
        release_out;
        wr(0, 0, 16'sh0100);
    endtask

    task automatic test_oob_write;
        wr(1, 2, 16'sh7000);
        wr(0, 5, 16'sh7000);
        wr(3, 3, 16'sh7000);
        wr(2, 6, 16'sh7000);
        wr(1, 7, 16'sh7000);
        test_basic("oob");
    endtask

    task automatic test_reset_mid;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b want 1", busy); end
        rst_n = 1'b0;
        #2;
        n_cmp++; if (in_ready !== 1'b1)    begin n_err++; $display("FAIL mid_rst_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0)   begin n_err++; $display("FAIL mid_rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_logits !== 48'h0) begin n_err++; $display("FAIL mid_rst_logits: got %h want 0", out_logits); end
        n_cmp++; if (out_class !== 2'd0)   begin n_err++; $display("FAIL mid_rst_class: got %0d want 0", out_class); end
        n_cmp++; if (busy !== 1'b0)        begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_basic("after_rst");
    endtask

    task automatic test_random;
        int cyc;
        logic [47:0] exp_l;
        logic [1:0]  exp_c;
        logic [15:0] x0;
        logic [15:0] x1;
        for (int a = 0; a < 4; a++) wr(0, a, 16'($urandom));
        for (int a = 0; a < 2; a++) wr(1, a, 16'($urandom));
        for (int a = 0; a < 6; a++) wr(2, a, 16'($urandom));
        for (int a = 0; a < 3; a++) wr(3, a, 16'($urandom));
        for (int v = 0; v < 10; v++) begin
            x0 = 16'($urandom);
            x1 = 16'($urandom);
            if (v % 3 == 0) x0 = 16'($urandom_range(0, 511));
            model_run(x0, x1, exp_l, exp_c);
            send(x0, x1);
            wait_out(cyc);
            n_cmp++; if (cyc !== LAT) begin n_err++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", v, cyc, LAT); end
            n_cmp++; if (out_logits !== exp_l) begin n_err++; $display("FAIL rnd_logits[%0d]: got %h want %h (x=%h,%h)", v, out_logits, exp_l, x0, x1); end
            n_cmp++; if (out_class !== exp_c) begin n_err++; $display("FAIL rnd_class[%0d]: got %0d want %0d", v, out_class, exp_c); end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            release_out;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_sel    = 2'd0;
        wr_addr   = '0;
        wr_data   = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        rst_n = 1'b1;
        @(posedge clk); #1;
        load_default;
        test_basic("basic");
        test_relu_tie;
        test_bias;
        test_sat;
        test_stall;
        test_write_handshake;
        test_oob_write;
        send(16'h0200, 16'h0300);
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
